mem_req_arbiter: RTL
====================

# mem_req_arbiter

Two-master arbiter sharing one SRAM-like memory port between the instruction fetch path and the data (load/store) path. It sits between the fetch/memory stages and the single external memory interface, and serialises requests with one transaction outstanding at a time. Data requests take priority. Instruction responses can be cancelled on pipeline flush so that stale instructions never reach the fetch stage.

## Interface
- No parameters; address and data are fixed at 32 bits.
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- inst_req  in  1  fetch request valid (read only)
- inst_addr  in  32  fetch address
- inst_cancel  in  1  flush: discard any outstanding or new fetch
- inst_addr_ok  out  1  fetch request accepted this cycle
- inst_data_ok  out  1  fetch data valid this cycle
- inst_rdata  out  32  fetch data
- data_req  in  1  data request valid
- data_wr  in  1  1 = store, 0 = load
- data_size  in  2  0 = byte, 1 = half, 2 = word
- data_addr  in  32  data address
- data_wdata  in  32  store data
- data_addr_ok  out  1  data request accepted this cycle
- data_data_ok  out  1  load data valid or store complete
- data_rdata  out  32  load data
- mem_req  out  1  downstream request valid
- mem_wr  out  1  downstream write
- mem_size  out  2  downstream size
- mem_addr  out  32  downstream address
- mem_wdata  out  32  downstream write data
- mem_addr_ok  in  1  downstream accepted request
- mem_data_ok  in  1  downstream response valid
- mem_rdata  in  32  downstream read data

## Operation
- FSM states: IDLE, ADDR, DATA. Registers:
  - owner (0 = inst, 1 = data)
  - drop flag
  - latched wr, size, addr, wdata
- IDLE
  - If data_req: data_addr_ok = 1 (combinational). Latch the data fields and set owner = 1. Go to ADDR.
  - Else if inst_req && !inst_cancel: inst_addr_ok = 1. Latch wr = 0, size = 2, addr = inst_addr, wdata = 0. Set owner = 0, drop = 0. Go to ADDR.
  - A cancelled fetch is never granted.
- ADDR
  - mem_req = 1 with the latched fields, held stable until mem_addr_ok.
  - On mem_addr_ok, go to DATA.
- DATA
  - mem_req = 0. Wait for mem_data_ok.
  - On mem_data_ok:
    - owner = 1: data_data_ok = 1, data_rdata = mem_rdata.
    - owner = 0 and drop = 0 and no inst_cancel this cycle: inst_data_ok = 1, inst_rdata = mem_rdata.
  - Return to IDLE.
- Cancel handling
  - inst_cancel in ADDR or DATA with owner = 0 sets drop.
  - The transaction still completes downstream (no abort). Its response is swallowed, i.e. inst_data_ok stays 0.
  - drop clears on return to IDLE.
- Either data_ok goes high only in DATA, in the cycle mem_data_ok is high. At most one upstream data_ok per cycle.
- addr_ok fires only in IDLE; never both addr_ok outputs in the same cycle.
- inst_rdata and data_rdata pass mem_rdata straight through. They are valid only while the matching data_ok is high.

## Timing
- Reset values: state IDLE, mem_req 0, all *_addr_ok and *_data_ok 0, drop 0, latched fields 0.
- Reset mid-transaction returns to IDLE. Any in-flight response is not forwarded.
- Request acceptance is combinational in IDLE: upstream addr_ok is in the same cycle as req.
- mem_req is first asserted in the cycle after acceptance.
- Minimum latency, request to data_ok: 2 cycles (req at T, mem_req at T+1 with mem_addr_ok, mem_data_ok at T+2).
- Minimum issue interval: 3 cycles per transaction. The next grant is possible in the cycle after data_ok.
- mem_* fields are held unchanged while mem_req = 1 and mem_addr_ok = 0.
- Simultaneous inst_req and data_req in IDLE: data wins; inst stays pending.
- inst_cancel in the same cycle as mem_data_ok for an inst transaction: response dropped.
- inst_cancel while owner = 1: no effect.

## Test plan
- Single fetch
  - Stimulus: inst_req at addr 0xbfc00000; memory gives addr_ok immediately and data_ok next cycle with 0x3c080001.
  - Required: inst_addr_ok at T, mem_req at T+1, inst_data_ok with rdata 0x3c080001 at T+2.
- Simultaneous requests
  - Stimulus: inst_req and data_req (load, word, 0x80001000) both high in IDLE.
  - Required: data granted first and completed. Inst granted in the cycle after data_data_ok; inst_data_ok follows.
- Back-pressure
  - Stimulus: memory holds mem_addr_ok low 3 cycles for a store (size 1, addr 0x80000002, wdata 0x1234).
  - Required: mem_req/addr/wdata/size stable for 4 cycles; data_data_ok one cycle after DATA entry.
- Cancel mid-flight
  - Stimulus: inst_cancel pulsed while a fetch is in DATA.
  - Required: mem_data_ok consumed, inst_data_ok stays 0, FSM returns to IDLE.
  - A subsequent fetch to 0xbfc00380 returns normally.
- Cancel at grant
  - Stimulus: inst_req with inst_cancel in IDLE.
  - Required: no inst_addr_ok, mem_req stays 0.
- Reset mid-transaction
  - Stimulus: reset asserted in ADDR.
  - Required: next cycle mem_req = 0 and all outputs 0; a later mem_data_ok produces no upstream data_ok.

Source files
------------

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: serialises instruction-fetch and data requests onto one
// SRAM-like memory port, one transaction outstanding, data path has priority.
// Fetch responses can be swallowed on pipeline flush via inst_cancel.
module mem_req_arbiter (
    input  logic        clk,
    input  logic        reset,

    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    input  logic        inst_cancel,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = 2;

    localparam logic [SW-1:0] SIZE_WORD = SW'(2);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2
    } state_e;

    state_e        state_q;
    logic          owner_q;     // 0 = inst, 1 = data
    logic          drop_q;      // swallow the pending fetch response
    logic          mem_req_q;
    logic          wr_q;
    logic [SW-1:0] size_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;

    logic grant_data_c;
    logic grant_inst_c;
    logic resp_c;

    // Grant and response decode; gated by reset so nothing leaks during a reset cycle
    always_comb begin
        grant_data_c = 1'b0;
        grant_inst_c = 1'b0;
        resp_c       = 1'b0;
        if (!reset) begin
            if (state_q == S_IDLE) begin
                grant_data_c = data_req;
                grant_inst_c = !data_req && inst_req && !inst_cancel;
            end
            resp_c = (state_q == S_DATA) && mem_data_ok;
        end
    end

    // Upstream handshakes: acceptance and response are same-cycle, rdata is a pass-through
    always_comb begin
        data_addr_ok = grant_data_c;
        inst_addr_ok = grant_inst_c;
        data_data_ok = resp_c && owner_q;
        inst_data_ok = resp_c && !owner_q && !drop_q && !inst_cancel;
        data_rdata   = mem_rdata;
        inst_rdata   = mem_rdata;
    end

    // Downstream request is driven purely from latched fields so it stays stable under back-pressure
    always_comb begin
        mem_req   = mem_req_q;
        mem_wr    = wr_q;
        mem_size  = size_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
    end

    // Arbitration FSM with latched request fields
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            owner_q   <= 1'b0;
            drop_q    <= 1'b0;
            mem_req_q <= 1'b0;
            wr_q      <= 1'b0;
            size_q    <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (grant_data_c) begin
                        wr_q      <= data_wr;
                        size_q    <= data_size;
                        addr_q    <= data_addr;
                        wdata_q   <= data_wdata;
                        owner_q   <= 1'b1;
                        drop_q    <= 1'b0;
                        mem_req_q <= 1'b1;
                        state_q   <= S_ADDR;
                    end else if (grant_inst_c) begin
                        wr_q      <= 1'b0;
                        size_q    <= SIZE_WORD;
                        addr_q    <= inst_addr;
                        wdata_q   <= '0;
                        owner_q   <= 1'b0;
                        drop_q    <= 1'b0;
                        mem_req_q <= 1'b1;
                        state_q   <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (!owner_q && inst_cancel) begin
                        drop_q <= 1'b1;
                    end
                    if (mem_addr_ok) begin
                        mem_req_q <= 1'b0;
                        state_q   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (!owner_q && inst_cancel) begin
                        drop_q <= 1'b1;
                    end
                    // Transaction always finishes downstream; drop is only relevant until here
                    if (mem_data_ok) begin
                        drop_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    mem_req_q <= 1'b0;
                    drop_q    <= 1'b0;
                    state_q   <= S_IDLE;
                end
            endcase
        end
    end

    // Handshake sanity: one grant and one response per cycle at most
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(inst_addr_ok && data_addr_ok))
                else $error("both addr_ok asserted");
            assert (!(inst_data_ok && data_data_ok))
                else $error("both data_ok asserted");
        end
    end

endmodule
